// File: rtl/adc_capture_dma_tx.sv
// Captures a programmable number of wide ADC beats into a local buffer, then
// replays them as one narrow AXI-Stream packet with tlast for the S2MM DMA.
module adc_capture_dma_tx #(
  parameter int SAMPLE_W    = 16,
  parameter int LANES       = 8,
  parameter int DEPTH_BEATS = 512,
  parameter int LEN_W       = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      arm,
  input  logic                      abort,
  input  logic [LEN_W-1:0]          capture_len,
  input  logic [SAMPLE_W*LANES-1:0] s_axis_tdata,
  input  logic                      s_axis_tvalid,
  output logic                      s_axis_tready,
  output logic [SAMPLE_W-1:0]       m_axis_tdata,
  output logic                      m_axis_tvalid,
  input  logic                      m_axis_tready,
  output logic                      m_axis_tlast,
  output logic                      busy,
  output logic                      done,
  output logic [1:0]                state_out
);

  localparam int BEAT_W = SAMPLE_W * LANES;
  localparam int AW     = $clog2(DEPTH_BEATS);
  localparam int PW     = AW + 1;
  localparam int LW     = (LANES > 1) ? $clog2(LANES) : 1;
  localparam logic [PW-1:0]    DEPTH_P   = PW'(DEPTH_BEATS);
  localparam logic [LEN_W-1:0] DEPTH_L   = LEN_W'(DEPTH_BEATS);
  localparam logic [LW-1:0]    LAST_LANE = LW'(LANES - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    DRAIN   = 2'd2
  } state_t;

  state_t state, state_n;

  logic [BEAT_W-1:0] mem [DEPTH_BEATS];
  logic [BEAT_W-1:0] rd_data, cur_beat;
  logic [PW-1:0]     len_q, wr_ptr, rd_ptr, out_beat, clamp_len;
  logic [LW-1:0]     lane;
  logic              rd_vld, cur_valid;
  logic              arm_ok, wr_en, last_wr, rd_en, load_cur, fire, final_fire;

  assign clamp_len  = (capture_len == '0 || capture_len > DEPTH_L) ? DEPTH_P : PW'(capture_len);
  assign arm_ok     = (state == IDLE) && arm && !abort;
  assign wr_en      = (state == CAPTURE) && s_axis_tvalid;
  assign last_wr    = wr_en && ((wr_ptr + PW'(1)) == len_q);
  assign fire       = cur_valid && m_axis_tready;
  assign final_fire = fire && m_axis_tlast;
  // rd_data doubles as the prefetch slot: it is refilled as soon as its beat
  // moves into cur_beat, so the lane 7 -> lane 0 crossing has no bubble.
  assign load_cur   = rd_vld && (!cur_valid || (fire && lane == LAST_LANE));
  assign rd_en      = (state == DRAIN) && (rd_ptr < len_q) && (!rd_vld || load_cur);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    if (arm) state_n = CAPTURE;
      CAPTURE: if (last_wr) state_n = DRAIN;
      DRAIN:   if (final_fire) state_n = IDLE;
      default: state_n = IDLE;
    endcase
    if (abort) state_n = IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      len_q     <= DEPTH_P;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      out_beat  <= '0;
      lane      <= '0;
      rd_vld    <= 1'b0;
      cur_valid <= 1'b0;
      cur_beat  <= '0;
    end else if (abort) begin
      rd_vld    <= 1'b0;
      cur_valid <= 1'b0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + PW'(1);
      if (rd_en) begin
        rd_ptr <= rd_ptr + PW'(1);
        rd_vld <= 1'b1;
      end else if (load_cur) begin
        rd_vld <= 1'b0;
      end
      // out_beat starts at all-ones so the first load lands on beat 0
      if (load_cur) begin
        cur_beat  <= rd_data;
        cur_valid <= 1'b1;
        lane      <= '0;
        out_beat  <= out_beat + PW'(1);
      end else if (fire) begin
        lane <= lane + LW'(1);
        if (lane == LAST_LANE) cur_valid <= 1'b0;
      end
      if (arm_ok) begin
        len_q     <= clamp_len;
        wr_ptr    <= '0;
        rd_ptr    <= '0;
        out_beat  <= '1;
        lane      <= '0;
        rd_vld    <= 1'b0;
        cur_valid <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr[AW-1:0]] <= s_axis_tdata;
    if (rd_en) rd_data <= mem[rd_ptr[AW-1:0]];
  end

  assign s_axis_tready = 1'b1;
  assign m_axis_tvalid = cur_valid;
  assign m_axis_tdata  = cur_beat[lane*SAMPLE_W +: SAMPLE_W];
  assign m_axis_tlast  = cur_valid && (lane == LAST_LANE) && (out_beat == (len_q - PW'(1)));
  assign done          = final_fire;
  assign busy          = (state != IDLE);
  assign state_out     = state;

endmodule

// File: doc/adc_capture_dma_tx.md
Name: adc_capture_dma_tx

Overview:
- Capture-and-readback block: the FPGA-to-CPU counterpart of the 16-bit CPU-to-FPGA DMA input stream.
- On an arm pulse it captures a programmable number of 128-bit ADC beats (8 x 16-bit samples each) into an internal buffer.
- It then serialises the buffer as a single 16-bit AXI-Stream packet with tlast, for the S2MM DMA back to the CPU.
- Sits beside the experiment top level on the MAC or NL ADC stream, in the 250 MHz domain.

Parameters:
- SAMPLE_W, 16, sample width and output tdata width
- LANES, 8, samples per input beat (input width = SAMPLE_W*LANES = 128)
- DEPTH_BEATS, 512, buffer depth in input beats (power of two)
- LEN_W, 16, width of capture_len

Ports:
- clk  in  1  system clock (250 MHz)
- rst  in  1  synchronous active-high reset
- arm  in  1  single-cycle start request
- abort  in  1  single-cycle abort request
- capture_len  in  LEN_W  beats to capture; sampled on accepted arm
- s_axis_tdata  in  128  ADC beat; lane k = bits [16k+15:16k]
- s_axis_tvalid  in  1  ADC beat valid
- s_axis_tready  out  1  always 1 (ADC cannot be stalled)
- m_axis_tdata  out  16  sample to DMA
- m_axis_tvalid  out  1  output valid
- m_axis_tready  in  1  DMA ready
- m_axis_tlast  out  1  final sample of packet
- busy  out  1  high in CAPTURE or DRAIN
- done  out  1  one-cycle pulse on the last output handshake
- state_out  out  2  0=IDLE, 1=CAPTURE, 2=DRAIN

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-high, named rst.
- Reset values: m_axis_tvalid=0, m_axis_tdata=0, m_axis_tlast=0, busy=0, done=0, state_out=0. Buffer contents are not reset.
- s_axis_tready=1 at all times, including during reset. Beats arriving outside CAPTURE are discarded.
- IDLE:
  - arm=1 latches len_q and moves to CAPTURE next cycle.
  - len_q = DEPTH_BEATS if capture_len==0 or capture_len>DEPTH_BEATS; otherwise len_q = capture_len.
  - Write pointer clears to 0.
- CAPTURE:
  - Each cycle with s_axis_tvalid=1 writes the beat to buffer[wr_ptr] and increments wr_ptr.
  - The beat that makes wr_ptr==len_q is the last one written; the next cycle is DRAIN.
  - Beats with tvalid=0 are skipped; there is no timeout.
- DRAIN:
  - Emits len_q*LANES samples in order: beat 0 lane 0, beat 0 lane 1, ..., beat len_q-1 lane 7.
  - Buffer read has 1-cycle latency. First m_axis_tvalid asserts exactly 2 cycles after entering DRAIN.
  - AXI-S rules: once tvalid=1, tdata, tlast and tvalid hold until tready=1.
  - Throughput is one sample per cycle while tready=1. The next beat is prefetched so that lane 7 -> lane 0 of the next beat causes no bubble.
  - tlast=1 only on the final sample.
  - On the tlast handshake: done pulses 1 cycle, state returns to IDLE, tvalid drops the next cycle.
- arm while busy is ignored, with no effect on len_q or pointers.
- arm in the same cycle as the final DRAIN handshake is ignored. A new arm is accepted from the IDLE cycle onward.
- abort (any state):
  - Next cycle is IDLE, tvalid=0, tlast=0, done=0, no packet end is emitted.
  - Intended only together with a DMA channel reset.
  - abort and arm in the same cycle: abort wins.
- rst mid-operation: identical to abort, plus all outputs at reset values.
- Counters:
  - Read counter: log2(DEPTH_BEATS)+1 bits for beats plus 3 bits for lane. No wrap-around is possible because len_q<=DEPTH_BEATS.
  - Sample count per packet = len_q*8, max 4096 at the defaults.

Test Plan:
- Basic packet: arm with capture_len=2, ADC beats with lane k of beat b = 16'h0b0k, tvalid continuous, tready=1 -> 16 samples 0x0000..0x0007, 0x0100..0x0107; tlast only on 0x0107; done pulses once; first tvalid exactly 2 cycles after state_out=2.
- Gapped input and backpressure: capture_len=3, tvalid toggling 1/0, tready random 50% -> 24 samples in exact order; tdata stable whenever tvalid=1 and tready=0; no duplicate or dropped samples.
- Length clamping: capture_len=0, then capture_len=600 (DEPTH 512) -> each packet is 4096 samples with tlast on the 4096th; capture_len=512 behaves the same.
- Arm ignored while busy: arm pulses at mid-CAPTURE and at mid-DRAIN with capture_len=5 -> packet stays 8x the original len; state sequence is unchanged.
- Abort and reset: abort during DRAIN after 10 samples -> tvalid=0 the next cycle, state_out=0, no done. Then arm capture_len=1 -> a clean 8-sample packet. Repeat using rst mid-CAPTURE -> all outputs at reset values the next cycle.
- Back-to-back: arm in the cycle after done with capture_len=1 -> second packet accepted; arm in the same cycle as the final handshake -> ignored.
